axi_lite_arb: RTL and testbench
===============================

# axi_lite_arb

Two-master, one-slave AXI-lite arbiter that shares the core's single memory port between the instruction fetch unit (M0, read-only) and the load/store unit (M1, read and write). It sits between the fetch and LSU AXI-lite masters and the memory/crossbar slave. It grants one whole transaction at a time, with fixed priority LSU over fetch, and forwards only the granted master's channels to the slave.

## Interface
- ADDR_WIDTH, 32, AXI address width.
- DATA_WIDTH, 32, AXI data width; strobe width is DATA_WIDTH/8, resp width is 2.
- clk  in  1  core clock; everything is sampled on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- M0 AR: m0_araddr in ADDR_WIDTH, m0_arvalid in 1, m0_arready out 1. Fetch read address.
- M0 R: m0_rdata out DATA_WIDTH, m0_rresp out 2, m0_rvalid out 1, m0_rready in 1. Fetch read data.
- M1 AR: m1_araddr in ADDR_WIDTH, m1_arvalid in 1, m1_arready out 1. LSU read address.
- M1 R: m1_rdata out DATA_WIDTH, m1_rresp out 2, m1_rvalid out 1, m1_rready in 1.
- M1 AW: m1_awaddr in ADDR_WIDTH, m1_awvalid in 1, m1_awready out 1.
- M1 W: m1_wdata in DATA_WIDTH, m1_wstrb in DATA_WIDTH/8, m1_wvalid in 1, m1_wready out 1.
- M1 B: m1_bresp out 2, m1_bvalid out 1, m1_bready in 1.
- S AR/R/AW/W/B: s_araddr, s_arvalid, s_arready, s_rdata, s_rresp, s_rvalid, s_rready, s_awaddr, s_awvalid, s_awready, s_wdata, s_wstrb, s_wvalid, s_wready, s_bresp, s_bvalid, s_bready. These mirror the M1 set with directions reversed: the arbiter drives valids and payload out and rready/bready out, and receives readies and response payload in.

## Operation
- FSM states: IDLE, RD_IF, RD_LS, WR_LS. Reset state is IDLE.
- Arbitration happens in IDLE only, evaluated in this order:
  - m1_awvalid → WR_LS.
  - Else m1_arvalid → RD_LS.
  - Else m0_arvalid → RD_IF.
  - Else stay in IDLE.
- The chosen state is registered. No channel is forwarded in IDLE.
- Per-grant done flags ar_done, aw_done, w_done:
  - Cleared on grant entry.
  - Each is set on its channel's slave handshake (e.g. s_arvalid && s_arready).
  - Once a flag is set, the forwarded s_*valid for that channel is held at 0 for the rest of the grant.
- RD_IF:
  - s_araddr=m0_araddr; s_arvalid=m0_arvalid && !ar_done; m0_arready=s_arready && !ar_done.
  - R channel: s_rready=m0_rready; m0_rvalid=s_rvalid; m0_rdata and m0_rresp come from the slave.
  - All M1 readies and valids are 0.
- RD_LS: same as RD_IF with M1 in place of M0. M0 and all write-side outputs are 0.
- WR_LS:
  - AW and W are forwarded independently with aw_done/w_done masking; W may arrive before, with or after AW.
  - B is forwarded: s_bready=m1_bready; m1_bvalid=s_bvalid.
  - All read-side outputs are 0.
- Grant completion:
  - RD_*: on the R handshake (s_rvalid && s_rready) → IDLE.
  - WR_LS: on the B handshake (s_bvalid && s_bready) → IDLE.
  - A B arriving before w_done is a slave protocol violation. It still completes the grant; no check is performed.
- Not granted: every ready or valid going to a non-granted master is 0. Payload outputs to the master are don't-care but are driven from the slave bus. Slave payload is don't-care when its valid is 0.
- Starvation: fetch can starve only while the LSU issues back-to-back requests. This is accepted by design, because the LSU's instruction is always the older one.

## Timing
- Reset values:
  - State IDLE, all done flags 0.
  - All s_*valid, s_rready, s_bready = 0.
  - All m*_arready, m1_awready, m1_wready, m*_rvalid, m1_bvalid = 0.
- Assertion of rst at any time, including mid-transaction, forces IDLE and the values above immediately. No in-flight response is forwarded afterwards.
- Latency:
  - A request seen in IDLE at edge n gives a grant state from n+1, and s_arvalid/s_awvalid can be high in cycle n+1. This is one cycle of arbitration latency.
  - A completion handshake in cycle m gives IDLE in cycle m+1; the next grant starts at m+2. There is one dead cycle between transactions.
- Simultaneous requests in IDLE: m1 write > m1 read > m0 read. A request that loses arbitration sees ready=0 and must hold valid per AXI.
- All master↔slave forwarding within a grant is combinational, with zero added latency.

## Test plan
- Fetch read alone: m0_araddr=0x8000_0000 with m0_arvalid; slave returns rdata=0x0000_0413 after 3 cycles → s_araddr=0x8000_0000 one cycle after request; m0 gets rdata=0x413 with rresp=0; back to IDLE the next cycle.
- Contention: m0_arvalid and m1_arvalid both rise in the same IDLE cycle → LSU read is granted first; fetch AR is accepted only after the LSU R handshake plus one IDLE cycle; m0_arready stays 0 until then.
- LSU write with W before AW: m1_wvalid at cycle 1 and m1_awvalid at cycle 3, addr 0x8000_1000, data 0xDEAD_BEEF, wstrb 0xF → grant at cycle 4; s_wvalid drops after its handshake; m1_bvalid is forwarded; IDLE after the B handshake.
- Slave holds s_arready=1 for several cycles while the master keeps arvalid high after the handshake → exactly one s_arvalid handshake per grant (ar_done masking).
- Reset mid-transaction: assert rst during RD_LS before rvalid → all outputs reset immediately; a later s_rvalid is not forwarded to m1_rvalid.
- Back-to-back LSU reads 0x10 and 0x14 with m0 pending → m0 is served only after both LSU reads, each pair of grants separated by exactly one IDLE cycle.

Source files
------------

// File: rtl/axi_lite_arb.sv
// axi_lite_arb: shares one AXI-lite slave port between the instruction fetch
// master (M0, read-only) and the load/store master (M1, read and write).
// One whole transaction is granted at a time. LSU write beats LSU read, which
// beats fetch read. Only the granted master's channels reach the slave.
module axi_lite_arb #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  // fetch master (M0): read address and read data
  input  logic [ADDR_WIDTH-1:0]     m0_araddr,
  input  logic                      m0_arvalid,
  output logic                      m0_arready,
  output logic [DATA_WIDTH-1:0]     m0_rdata,
  output logic [1:0]                m0_rresp,
  output logic                      m0_rvalid,
  input  logic                      m0_rready,
  // load/store master (M1): read address and read data
  input  logic [ADDR_WIDTH-1:0]     m1_araddr,
  input  logic                      m1_arvalid,
  output logic                      m1_arready,
  output logic [DATA_WIDTH-1:0]     m1_rdata,
  output logic [1:0]                m1_rresp,
  output logic                      m1_rvalid,
  input  logic                      m1_rready,
  // load/store master (M1): write address, write data, write response
  input  logic [ADDR_WIDTH-1:0]     m1_awaddr,
  input  logic                      m1_awvalid,
  output logic                      m1_awready,
  input  logic [DATA_WIDTH-1:0]     m1_wdata,
  input  logic [DATA_WIDTH/8-1:0]   m1_wstrb,
  input  logic                      m1_wvalid,
  output logic                      m1_wready,
  output logic [1:0]                m1_bresp,
  output logic                      m1_bvalid,
  input  logic                      m1_bready,
  // shared slave port
  output logic [ADDR_WIDTH-1:0]     s_araddr,
  output logic                      s_arvalid,
  input  logic                      s_arready,
  input  logic [DATA_WIDTH-1:0]     s_rdata,
  input  logic [1:0]                s_rresp,
  input  logic                      s_rvalid,
  output logic                      s_rready,
  output logic [ADDR_WIDTH-1:0]     s_awaddr,
  output logic                      s_awvalid,
  input  logic                      s_awready,
  output logic [DATA_WIDTH-1:0]     s_wdata,
  output logic [DATA_WIDTH/8-1:0]   s_wstrb,
  output logic                      s_wvalid,
  input  logic                      s_wready,
  input  logic [1:0]                s_bresp,
  input  logic                      s_bvalid,
  output logic                      s_bready
);

  typedef enum logic [1:0] {
    IDLE,
    RD_IF,
    RD_LS,
    WR_LS
  } state_t;

  state_t state;
  state_t state_next;

  logic ar_done;
  logic aw_done;
  logic w_done;

  logic ar_hs;
  logic aw_hs;
  logic w_hs;

  // Slave-side request handshakes mark a channel as finished for this grant.
  assign ar_hs = s_arvalid && s_arready;
  assign aw_hs = s_awvalid && s_awready;
  assign w_hs  = s_wvalid  && s_wready;

  // Response payload and write payload go straight through; the valids and
  // readies alone decide whether anyone looks at them.
  assign m0_rdata = s_rdata;
  assign m0_rresp = s_rresp;
  assign m1_rdata = s_rdata;
  assign m1_rresp = s_rresp;
  assign m1_bresp = s_bresp;
  assign s_awaddr = m1_awaddr;
  assign s_wdata  = m1_wdata;
  assign s_wstrb  = m1_wstrb;

  // Grant state register; reset drops any grant immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Done flags stay clear in IDLE, so each grant starts with all channels open.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ar_done <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else if (state == IDLE) begin
      ar_done <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      if (ar_hs) ar_done <= 1'b1;
      if (aw_hs) aw_done <= 1'b1;
      if (w_hs)  w_done  <= 1'b1;
    end
  end

  // Arbitration in IDLE plus combinational forwarding of the granted master.
  always_comb begin
    state_next = state;
    s_araddr   = m1_araddr;
    s_arvalid  = 1'b0;
    s_rready   = 1'b0;
    s_awvalid  = 1'b0;
    s_wvalid   = 1'b0;
    s_bready   = 1'b0;
    m0_arready = 1'b0;
    m0_rvalid  = 1'b0;
    m1_arready = 1'b0;
    m1_rvalid  = 1'b0;
    m1_awready = 1'b0;
    m1_wready  = 1'b0;
    m1_bvalid  = 1'b0;

    case (state)
      IDLE: begin
        if (m1_awvalid) begin
          state_next = WR_LS;
        end else if (m1_arvalid) begin
          state_next = RD_LS;
        end else if (m0_arvalid) begin
          state_next = RD_IF;
        end
      end

      RD_IF: begin
        s_araddr   = m0_araddr;
        s_arvalid  = m0_arvalid && !ar_done;
        m0_arready = s_arready && !ar_done;
        s_rready   = m0_rready;
        m0_rvalid  = s_rvalid;
        if (s_rvalid && m0_rready) begin
          state_next = IDLE;
        end
      end

      RD_LS: begin
        s_araddr   = m1_araddr;
        s_arvalid  = m1_arvalid && !ar_done;
        m1_arready = s_arready && !ar_done;
        s_rready   = m1_rready;
        m1_rvalid  = s_rvalid;
        if (s_rvalid && m1_rready) begin
          state_next = IDLE;
        end
      end

      WR_LS: begin
        // AW and W are independent; a W seen before AW is simply accepted first.
        s_awvalid  = m1_awvalid && !aw_done;
        m1_awready = s_awready && !aw_done;
        s_wvalid   = m1_wvalid && !w_done;
        m1_wready  = s_wready && !w_done;
        s_bready   = m1_bready;
        m1_bvalid  = s_bvalid;
        // A B response ends the grant even if the slave sent it before taking W.
        if (s_bvalid && m1_bready) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_axi_lite_arb.sv
// tb_axi_lite_arb: directed scenarios for the arbiter followed by randomized
// rounds of simultaneous requests checked against a transaction-level model.
module tb_axi_lite_arb;

  logic        clk;
  logic        rst;
  logic [31:0] m0_araddr;
  logic        m0_arvalid;
  logic        m0_arready;
  logic [31:0] m0_rdata;
  logic [1:0]  m0_rresp;
  logic        m0_rvalid;
  logic        m0_rready;
  logic [31:0] m1_araddr;
  logic        m1_arvalid;
  logic        m1_arready;
  logic [31:0] m1_rdata;
  logic [1:0]  m1_rresp;
  logic        m1_rvalid;
  logic        m1_rready;
  logic [31:0] m1_awaddr;
  logic        m1_awvalid;
  logic        m1_awready;
  logic [31:0] m1_wdata;
  logic [3:0]  m1_wstrb;
  logic        m1_wvalid;
  logic        m1_wready;
  logic [1:0]  m1_bresp;
  logic        m1_bvalid;
  logic        m1_bready;
  logic [31:0] s_araddr;
  logic        s_arvalid;
  logic        s_arready;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rvalid;
  logic        s_rready;
  logic [31:0] s_awaddr;
  logic        s_awvalid;
  logic        s_awready;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_wvalid;
  logic        s_wready;
  logic [1:0]  s_bresp;
  logic        s_bvalid;
  logic        s_bready;

  // one-hot masks for the packed handshake-control vector
  localparam logic [11:0] SARV  = 12'h800;
  localparam logic [11:0] SRRD  = 12'h400;
  localparam logic [11:0] SAWV  = 12'h200;
  localparam logic [11:0] SWV   = 12'h100;
  localparam logic [11:0] SBRD  = 12'h080;
  localparam logic [11:0] M0ARR = 12'h040;
  localparam logic [11:0] M0RV  = 12'h020;
  localparam logic [11:0] M1ARR = 12'h010;
  localparam logic [11:0] M1RV  = 12'h008;
  localparam logic [11:0] M1AWR = 12'h004;
  localparam logic [11:0] M1WR  = 12'h002;
  localparam logic [11:0] M1BV  = 12'h001;

  localparam int K_F  = 0;
  localparam int K_LR = 1;
  localparam int K_W  = 2;

  int passed;
  int total;
  int hs_count;

  logic [9:0]  e_m1ar;
  logic [9:0]  e_m1rv;
  logic [9:0]  e_m0ar;
  logic [9:0]  e_m0rv;
  logic        r_pend;

  int          cyc;
  int          next_start;
  int          round_start;
  int          idle_from;
  int          rounds_done;
  int          k;
  int          r_delay;
  int          b_delay;
  int          w_delay;
  int          order[$];
  logic        active;
  logic        round_live;
  logic        timed_out;
  logic        ar_d;
  logic        aw_d;
  logic        w_d;
  logic        f_pend;
  logic        lr_pend;
  logic        aw_pend;
  logic        w_pend;
  logic        r_active;
  logic        b_active;
  logic        b_issued;
  logic        aw_got;
  logic        w_got;
  logic        do_f;
  logic        do_lr;
  logic        do_w;
  logic        is_f;
  logic        is_lr;
  logic        is_w;
  logic        e_sar;
  logic        e_srr;
  logic        e_saw;
  logic        e_sw;
  logic        e_sbr;
  logic [11:0] exp_bits;
  logic [31:0] f_addr;
  logic [31:0] lr_addr;
  logic [31:0] w_addr;
  logic [31:0] w_data;
  logic [31:0] r_addr_s;
  logic [3:0]  w_strb;
  logic [1:0]  r_resp;
  logic [1:0]  b_resp;

  axi_lite_arb #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .m0_araddr  (m0_araddr),
    .m0_arvalid (m0_arvalid),
    .m0_arready (m0_arready),
    .m0_rdata   (m0_rdata),
    .m0_rresp   (m0_rresp),
    .m0_rvalid  (m0_rvalid),
    .m0_rready  (m0_rready),
    .m1_araddr  (m1_araddr),
    .m1_arvalid (m1_arvalid),
    .m1_arready (m1_arready),
    .m1_rdata   (m1_rdata),
    .m1_rresp   (m1_rresp),
    .m1_rvalid  (m1_rvalid),
    .m1_rready  (m1_rready),
    .m1_awaddr  (m1_awaddr),
    .m1_awvalid (m1_awvalid),
    .m1_awready (m1_awready),
    .m1_wdata   (m1_wdata),
    .m1_wstrb   (m1_wstrb),
    .m1_wvalid  (m1_wvalid),
    .m1_wready  (m1_wready),
    .m1_bresp   (m1_bresp),
    .m1_bvalid  (m1_bvalid),
    .m1_bready  (m1_bready),
    .s_araddr   (s_araddr),
    .s_arvalid  (s_arvalid),
    .s_arready  (s_arready),
    .s_rdata    (s_rdata),
    .s_rresp    (s_rresp),
    .s_rvalid   (s_rvalid),
    .s_rready   (s_rready),
    .s_awaddr   (s_awaddr),
    .s_awvalid  (s_awvalid),
    .s_awready  (s_awready),
    .s_wdata    (s_wdata),
    .s_wstrb    (s_wstrb),
    .s_wvalid   (s_wvalid),
    .s_wready   (s_wready),
    .s_bresp    (s_bresp),
    .s_bvalid   (s_bvalid),
    .s_bready   (s_bready)
  );

  // free-running 10-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // all handshake controls the arbiter drives, packed for one-shot comparison
  function automatic logic [11:0] ctrl_bits();
    return {s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready,
            m0_arready, m0_rvalid, m1_arready, m1_rvalid,
            m1_awready, m1_wready, m1_bvalid};
  endfunction

  // slave memory contents: a fixed scramble of the address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0413;
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic check_ctrl(input string tag, input logic [11:0] exp);
    check_output(tag, {20'd0, ctrl_bits()}, {20'd0, exp});
  endtask

  // inputs change just after the rising edge
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m0_araddr  = '0; m0_arvalid = 1'b0; m0_rready = 1'b0;
    m1_araddr  = '0; m1_arvalid = 1'b0; m1_rready = 1'b0;
    m1_awaddr  = '0; m1_awvalid = 1'b0;
    m1_wdata   = '0; m1_wstrb   = '0;   m1_wvalid = 1'b0;
    m1_bready  = 1'b0;
    s_arready  = 1'b0; s_rdata = '0; s_rresp = '0; s_rvalid = 1'b0;
    s_awready  = 1'b0; s_wready = 1'b0; s_bresp = '0; s_bvalid = 1'b0;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    clear_inputs();
    rst = 1'b1;

    // ---- reset state ----
    @(negedge clk);
    check_ctrl("reset_ctrl", 12'h000);
    next_cycle();
    next_cycle();
    rst = 1'b0;

    // ---- fetch read alone ----
    next_cycle();
    m0_araddr = 32'h8000_0000; m0_arvalid = 1'b1; m0_rready = 1'b1; s_arready = 1'b1;
    @(negedge clk);
    check_ctrl("fetch_idle_no_fwd", 12'h000);
    next_cycle();
    @(negedge clk);
    check_ctrl("fetch_ar_grant", SARV | SRRD | M0ARR);
    check_output("fetch_araddr", s_araddr, 32'h8000_0000);
    next_cycle();
    m0_arvalid = 1'b0;
    @(negedge clk);
    check_ctrl("fetch_wait_r", SRRD);
    next_cycle();
    next_cycle();
    s_rvalid = 1'b1; s_rdata = 32'h0000_0413; s_rresp = 2'b00;
    @(negedge clk);
    check_ctrl("fetch_r_fwd", SRRD | M0RV);
    check_output("fetch_rdata", m0_rdata, 32'h0000_0413);
    check_output("fetch_rresp", {30'd0, m0_rresp}, 32'd0);
    next_cycle();
    s_rvalid = 1'b0;
    @(negedge clk);
    check_ctrl("fetch_back_idle", 12'h000);

    // ---- contention: LSU read wins over fetch ----
    next_cycle();
    m0_araddr = 32'h0000_0100; m0_arvalid = 1'b1; m0_rready = 1'b1;
    m1_araddr = 32'h0000_0200; m1_arvalid = 1'b1; m1_rready = 1'b1;
    @(negedge clk);
    check_ctrl("cont_idle", 12'h000);
    next_cycle();
    @(negedge clk);
    check_ctrl("cont_lsu_grant", SARV | SRRD | M1ARR);
    check_output("cont_lsu_araddr", s_araddr, 32'h0000_0200);
    next_cycle();
    m1_arvalid = 1'b0; s_rvalid = 1'b1; s_rdata = 32'h1111_2222;
    @(negedge clk);
    check_ctrl("cont_lsu_r", SRRD | M1RV);
    check_output("cont_lsu_rdata", m1_rdata, 32'h1111_2222);
    next_cycle();
    s_rvalid = 1'b0;
    @(negedge clk);
    check_ctrl("cont_dead_cycle", 12'h000);
    next_cycle();
    @(negedge clk);
    check_ctrl("cont_fetch_grant", SARV | SRRD | M0ARR);
    check_output("cont_fetch_araddr", s_araddr, 32'h0000_0100);
    next_cycle();
    m0_arvalid = 1'b0; s_rvalid = 1'b1; s_rdata = 32'h3333_4444;
    @(negedge clk);
    check_ctrl("cont_fetch_r", SRRD | M0RV);
    check_output("cont_fetch_rdata", m0_rdata, 32'h3333_4444);
    next_cycle();
    s_rvalid = 1'b0; m0_rready = 1'b0; m1_rready = 1'b0;
    @(negedge clk);
    check_ctrl("cont_idle_end", 12'h000);

    // ---- LSU write with W ahead of AW ----
    next_cycle();
    m1_wvalid = 1'b1; m1_wdata = 32'hDEAD_BEEF; m1_wstrb = 4'hF;
    s_awready = 1'b1; s_wready = 1'b1;
    @(negedge clk);
    check_ctrl("wr_w_early_c1", 12'h000);
    next_cycle();
    @(negedge clk);
    check_ctrl("wr_w_early_c2", 12'h000);
    next_cycle();
    m1_awvalid = 1'b1; m1_awaddr = 32'h8000_1000;
    @(negedge clk);
    check_ctrl("wr_aw_c3_idle", 12'h000);
    next_cycle();
    @(negedge clk);
    check_ctrl("wr_grant_c4", SAWV | SWV | M1AWR | M1WR);
    check_output("wr_awaddr", s_awaddr, 32'h8000_1000);
    check_output("wr_wdata", s_wdata, 32'hDEAD_BEEF);
    check_output("wr_wstrb", {28'd0, s_wstrb}, 32'h0000_000F);
    next_cycle();
    s_bvalid = 1'b1; s_bresp = 2'b10;
    @(negedge clk);
    check_ctrl("wr_masked_b_fwd", M1BV);
    next_cycle();
    m1_awvalid = 1'b0; m1_wvalid = 1'b0; m1_bready = 1'b1;
    @(negedge clk);
    check_ctrl("wr_b_hs", SBRD | M1BV);
    check_output("wr_bresp", {30'd0, m1_bresp}, 32'd2);
    next_cycle();
    s_bvalid = 1'b0; m1_bready = 1'b0; s_awready = 1'b0; s_wready = 1'b0;
    @(negedge clk);
    check_ctrl("wr_back_idle", 12'h000);

    // ---- one AR handshake per grant while arvalid stays high ----
    hs_count = 0;
    next_cycle();
    m1_arvalid = 1'b1; m1_araddr = 32'h0000_0040; s_arready = 1'b1; m1_rready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (c == 4) begin
        m1_arvalid = 1'b0; s_rvalid = 1'b1; s_rdata = 32'h0BAD_F00D;
      end
      if (c == 5) s_rvalid = 1'b0;
      @(negedge clk);
      if (s_arvalid && s_arready) hs_count++;
      if (c == 2) check_ctrl("armask_held", SRRD);
      next_cycle();
    end
    check_output("armask_hs_count", hs_count, 32'd1);

    // ---- reset in the middle of an LSU read ----
    m1_arvalid = 1'b1; m1_araddr = 32'h0000_0080;
    @(negedge clk);
    next_cycle();
    @(negedge clk);
    check_ctrl("rst_pre_grant", SARV | SRRD | M1ARR);
    next_cycle();
    m1_arvalid = 1'b0;
    #1;
    check_ctrl("rst_in_grant", SRRD);
    rst = 1'b1;
    #1;
    check_ctrl("rst_immediate", 12'h000);
    @(negedge clk);
    check_ctrl("rst_held", 12'h000);
    next_cycle();
    rst = 1'b0; s_rvalid = 1'b1; s_rdata = 32'h7777_7777;
    @(negedge clk);
    check_ctrl("rst_no_late_r", 12'h000);
    next_cycle();
    clear_inputs();

    // ---- back-to-back LSU reads with fetch pending ----
    e_m1ar = 10'b0100100000;
    e_m1rv = 10'b0010010000;
    e_m0ar = 10'b0000000100;
    e_m0rv = 10'b0000000010;
    r_pend = 1'b0;
    for (int c = 0; c < 10; c++) begin
      next_cycle();
      m1_arvalid = (c <= 4);
      m1_araddr  = (c <= 1) ? 32'h0000_0010 : 32'h0000_0014;
      m0_arvalid = (c <= 7);
      m0_araddr  = 32'h8000_0004;
      s_arready  = 1'b1; m1_rready = 1'b1; m0_rready = 1'b1;
      s_rvalid   = r_pend; s_rdata = 32'h5000_0000 + 32'(c);
      @(negedge clk);
      check_output($sformatf("b2b_c%0d", c),
                   {28'd0, m1_arready, m1_rvalid, m0_arready, m0_rvalid},
                   {28'd0, e_m1ar[9-c], e_m1rv[9-c], e_m0ar[9-c], e_m0rv[9-c]});
      if (c == 1) check_output("b2b_addr0", s_araddr, 32'h0000_0010);
      if (c == 4) check_output("b2b_addr1", s_araddr, 32'h0000_0014);
      if (c == 7) check_output("b2b_addr2", s_araddr, 32'h8000_0004);
      r_pend = s_arvalid && s_arready;
    end

    // ---- randomized rounds against the transaction model ----
    next_cycle();
    clear_inputs();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    cyc = 0; idle_from = 0; rounds_done = 0; round_live = 1'b0; timed_out = 1'b0;
    active = 1'b0; next_start = 0; round_start = 0;
    f_pend = 1'b0; lr_pend = 1'b0; aw_pend = 1'b0; w_pend = 1'b0; w_delay = 0;
    r_active = 1'b0; b_active = 1'b0; b_issued = 1'b0; aw_got = 1'b0; w_got = 1'b0;
    r_delay = 0; b_delay = 0; ar_d = 1'b0; aw_d = 1'b0; w_d = 1'b0;
    f_addr = '0; lr_addr = '0; w_addr = '0; w_data = '0; w_strb = '0;
    r_addr_s = '0; r_resp = '0; b_resp = '0;

    while (rounds_done < 60 && !timed_out) begin
      next_cycle();
      if (!round_live && cyc >= idle_from) begin
        do_w  = 1'($urandom_range(0, 1));
        do_lr = 1'($urandom_range(0, 1));
        do_f  = 1'($urandom_range(0, 1));
        if (!do_w && !do_lr && !do_f) do_f = 1'b1;
        order.delete();
        if (do_w)  order.push_back(K_W);
        if (do_lr) order.push_back(K_LR);
        if (do_f)  order.push_back(K_F);
        f_addr  = $urandom() & 32'hFFFF_FFFC;
        lr_addr = $urandom() & 32'hFFFF_FFFC;
        w_addr  = $urandom() & 32'hFFFF_FFFC;
        w_data  = $urandom();
        w_strb  = 4'($urandom_range(1, 15));
        f_pend  = do_f; lr_pend = do_lr; aw_pend = do_w; w_pend = do_w;
        w_delay = $urandom_range(0, 2);
        aw_got = 1'b0; w_got = 1'b0; b_issued = 1'b0;
        round_live = 1'b1; round_start = cyc; next_start = cyc + 1;
      end
      m0_arvalid = f_pend;  m0_araddr = f_addr;  m0_rready = 1'($urandom_range(0, 1));
      m1_arvalid = lr_pend; m1_araddr = lr_addr; m1_rready = 1'($urandom_range(0, 1));
      m1_awvalid = aw_pend; m1_awaddr = w_addr;
      m1_wvalid  = w_pend && (w_delay == 0); m1_wdata = w_data; m1_wstrb = w_strb;
      m1_bready  = 1'($urandom_range(0, 1));
      s_arready  = 1'($urandom_range(0, 1));
      s_awready  = 1'($urandom_range(0, 1));
      s_wready   = 1'($urandom_range(0, 1));
      s_rvalid   = r_active && (r_delay == 0); s_rdata = mem_word(r_addr_s); s_rresp = r_resp;
      s_bvalid   = b_active && (b_delay == 0); s_bresp = b_resp;

      @(negedge clk);
      if (!active && order.size() > 0 && cyc == next_start) begin
        active = 1'b1; ar_d = 1'b0; aw_d = 1'b0; w_d = 1'b0;
      end
      k     = active ? order[0] : -1;
      is_f  = (k == K_F);
      is_lr = (k == K_LR);
      is_w  = (k == K_W);
      e_sar = ((is_f && m0_arvalid) || (is_lr && m1_arvalid)) && !ar_d;
      e_srr = (is_f && m0_rready) || (is_lr && m1_rready);
      e_saw = is_w && m1_awvalid && !aw_d;
      e_sw  = is_w && m1_wvalid && !w_d;
      e_sbr = is_w && m1_bready;
      exp_bits = {e_sar, e_srr, e_saw, e_sw, e_sbr,
                  is_f && s_arready && !ar_d, is_f && s_rvalid,
                  is_lr && s_arready && !ar_d, is_lr && s_rvalid,
                  is_w && s_awready && !aw_d, is_w && s_wready && !w_d,
                  is_w && s_bvalid};
      check_ctrl("rnd_ctrl", exp_bits);
      if (e_sar) check_output("rnd_araddr", s_araddr, is_f ? f_addr : lr_addr);

      if (r_active && r_delay > 0) r_delay--;
      if (b_active && b_delay > 0) b_delay--;
      if (w_pend && w_delay > 0) w_delay--;

      if (e_sar && s_arready) begin
        ar_d = 1'b1;
        if (is_f) f_pend = 1'b0; else lr_pend = 1'b0;
        r_active = 1'b1;
        r_delay  = $urandom_range(0, 2);
        r_addr_s = is_f ? f_addr : lr_addr;
        r_resp   = 2'($urandom_range(0, 3));
      end else if (s_rvalid && e_srr) begin
        if (is_f) begin
          check_output("rnd_m0_rdata", m0_rdata, mem_word(f_addr));
          check_output("rnd_m0_rresp", {30'd0, m0_rresp}, {30'd0, r_resp});
        end else begin
          check_output("rnd_m1_rdata", m1_rdata, mem_word(lr_addr));
          check_output("rnd_m1_rresp", {30'd0, m1_rresp}, {30'd0, r_resp});
        end
        r_active = 1'b0; active = 1'b0;
        void'(order.pop_front());
        next_start = cyc + 2;
      end
      if (e_saw && s_awready) begin
        check_output("rnd_awaddr", s_awaddr, w_addr);
        aw_d = 1'b1; aw_pend = 1'b0; aw_got = 1'b1;
      end
      if (e_sw && s_wready) begin
        check_output("rnd_wdata", s_wdata, w_data);
        check_output("rnd_wstrb", {28'd0, s_wstrb}, {28'd0, w_strb});
        w_d = 1'b1; w_pend = 1'b0; w_got = 1'b1;
      end
      if (s_bvalid && e_sbr) begin
        check_output("rnd_bresp", {30'd0, m1_bresp}, {30'd0, b_resp});
        b_active = 1'b0; active = 1'b0;
        void'(order.pop_front());
        next_start = cyc + 2;
      end
      if (aw_got && w_got && !b_issued) begin
        b_issued = 1'b1; b_active = 1'b1;
        b_delay  = $urandom_range(0, 2);
        b_resp   = 2'($urandom_range(0, 3));
      end

      if (round_live && order.size() == 0 && !active) begin
        round_live = 1'b0;
        rounds_done++;
        idle_from = cyc + 1 + $urandom_range(0, 2);
      end
      if (round_live && (cyc - round_start) > 200) begin
        total++;
        $error("[TB] FAIL rnd_timeout: round %0d still open after %0d cycles, required at most 200",
               rounds_done, cyc - round_start);
        timed_out = 1'b1;
      end
      cyc++;
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
